bdd_table_loader: RTL and testbench

Upstream loader for the BDD/decision-tree classifier core. It receives a byte stream over a valid/ready handshake and parses a framed node-table image. It assembles each node's 34-bit coefficient/threshold word and 18-bit child-pointer word, then drives the classifier's shared write port: `we1`, `in_addr`, `ram1_data_in` and `ram2_data_in`. Each write is held long enough for the divided-clock node SRAMs to capture it, and the block reports frame success or error.

---
 rtl/bdd_pkg.sv | 21 ++
 rtl/bdd_wr_hold.sv | 29 ++
 rtl/bdd_table_loader.sv | 155 +++++++++++++++
 tb/tb_bdd_table_loader.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bdd_pkg.sv
// Shared constants, widths and parser state encoding for the BDD node-table loader
// and the classifier core it feeds.
package bdd_pkg;
  localparam logic [7:0] HDR_BYTE    = 8'hA5;
  localparam int         R1_BYTES    = 5;
  localparam int         R2_BYTES    = 3;
  localparam int         RAM1_DW     = 34;
  localparam int         RAM2_DW     = 18;
  localparam int         NODE_AW     = 8;
  localparam int         NODE_DEPTH  = 32;
  localparam int         WR_HOLD_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COUNT,
    ST_R1,
    ST_R2,
    ST_WRITE,
    ST_CSUM
  } state_e;
endpackage

// File: rtl/bdd_wr_hold.sv
// Write-enable stretcher: holds we for WR_HOLD clk cycles so the divided-clock
// node SRAMs see at least one of their own edges during the write.
module bdd_wr_hold #(
  parameter int WR_HOLD = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic we,
  output logic done
);
  localparam int CW = $clog2(WR_HOLD + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start)              cnt_d = CW'(WR_HOLD);
    else if (cnt_q != '0)   cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign we   = (cnt_q != '0);
  assign done = (cnt_q == CW'(1));
endmodule

// File: rtl/bdd_table_loader.sv
// Parses a framed node-table byte stream (A5, N, N x 8 node bytes, XOR checksum)
// and drives the classifier's shared node-SRAM write port.
module bdd_table_loader
  import bdd_pkg::*;
#(
  parameter int RAM1_DATA_WIDTH = RAM1_DW,
  parameter int RAM2_DATA_WIDTH = RAM2_DW,
  parameter int ADDR_WIDTH      = NODE_AW,
  parameter int DEPTH           = NODE_DEPTH,
  parameter int WR_HOLD         = WR_HOLD_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [7:0]                 s_data,
  output logic                       we1,
  output logic [ADDR_WIDTH-1:0]      in_addr,
  output logic [RAM1_DATA_WIDTH-1:0] ram1_data_in,
  output logic [RAM2_DATA_WIDTH-1:0] ram2_data_in,
  output logic                       busy,
  output logic                       load_done,
  output logic                       load_err
);
  localparam int IW = ADDR_WIDTH + 1;

  state_e                     state_q, state_d;
  logic [2:0]                 bcnt_q, bcnt_d;
  // Only the bits that reach the SRAM are kept; the dropped upper bytes still feed the XOR.
  logic [RAM1_DATA_WIDTH-1:0] sh1_q, sh1_d;
  logic [RAM2_DATA_WIDTH-1:0] sh2_q, sh2_d, sh2_nxt;
  logic [IW-1:0]              n_q, n_d, idx_q, idx_d, idx_inc;
  logic [7:0]                 xor_q, xor_d;
  logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
  logic [RAM1_DATA_WIDTH-1:0] ram1_q, ram1_d;
  logic [RAM2_DATA_WIDTH-1:0] ram2_q, ram2_d;
  logic                       done_q, done_d, err_q, err_d;
  logic                       acc, hold_start, hold_done, hold_we;

  bdd_wr_hold #(.WR_HOLD(WR_HOLD)) u_wr_hold (
    .clk   (clk),
    .rst_n (rst_n),
    .start (hold_start),
    .we    (hold_we),
    .done  (hold_done)
  );

  assign s_ready = rst_n && (state_q != ST_WRITE);
  assign acc     = s_valid && s_ready;
  assign sh2_nxt = {sh2_q[RAM2_DATA_WIDTH-9:0], s_data};
  assign idx_inc = idx_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    bcnt_d     = bcnt_q;
    sh1_d      = sh1_q;
    sh2_d      = sh2_q;
    n_d        = n_q;
    idx_d      = idx_q;
    xor_d      = xor_q;
    addr_d     = addr_q;
    ram1_d     = ram1_q;
    ram2_d     = ram2_q;
    done_d     = done_q;
    err_d      = err_q;
    hold_start = 1'b0;
    case (state_q)
      ST_IDLE: if (acc && s_data == HDR_BYTE) begin
        state_d = ST_COUNT;
        done_d  = 1'b0;
        err_d   = 1'b0;
      end
      ST_COUNT: if (acc) begin
        if (s_data == 8'h00 || int'(s_data) > DEPTH) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          n_d     = IW'(s_data);
          idx_d   = '0;
          xor_d   = s_data;   // checksum covers N as well as the node bytes
          bcnt_d  = '0;
          state_d = ST_R1;
        end
      end
      ST_R1: if (acc) begin
        sh1_d = {sh1_q[RAM1_DATA_WIDTH-9:0], s_data};
        xor_d = xor_q ^ s_data;
        if (bcnt_q == 3'(R1_BYTES - 1)) begin
          bcnt_d  = '0;
          state_d = ST_R2;
        end else bcnt_d = bcnt_q + 1'b1;
      end
      ST_R2: if (acc) begin
        sh2_d = sh2_nxt;
        xor_d = xor_q ^ s_data;
        if (bcnt_q == 3'(R2_BYTES - 1)) begin
          bcnt_d     = '0;
          ram1_d     = sh1_q;
          ram2_d     = sh2_nxt;
          addr_d     = idx_q[ADDR_WIDTH-1:0];
          hold_start = 1'b1;
          state_d    = ST_WRITE;
        end else bcnt_d = bcnt_q + 1'b1;
      end
      ST_WRITE: if (hold_done) begin
        idx_d   = idx_inc;
        state_d = (idx_inc < n_q) ? ST_R1 : ST_CSUM;
      end
      ST_CSUM: if (acc) begin
        if (s_data == xor_q) done_d = 1'b1;
        else                 err_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      bcnt_q  <= '0;
      sh1_q   <= '0;
      sh2_q   <= '0;
      n_q     <= '0;
      idx_q   <= '0;
      xor_q   <= '0;
      addr_q  <= '0;
      ram1_q  <= '0;
      ram2_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      sh1_q   <= sh1_d;
      sh2_q   <= sh2_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      xor_q   <= xor_d;
      addr_q  <= addr_d;
      ram1_q  <= ram1_d;
      ram2_q  <= ram2_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign we1          = hold_we;
  assign in_addr      = addr_q;
  assign ram1_data_in = ram1_q;
  assign ram2_data_in = ram2_q;
  assign busy         = (state_q != ST_IDLE);
  assign load_done    = done_q;
  assign load_err     = err_q;
endmodule

// File: tb/tb_bdd_table_loader.sv
// Scenario bench for bdd_table_loader: expected SRAM writes go into a queue as
// frames are driven and are popped by a monitor on each rising we1.
module tb_bdd_table_loader;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        s_valid = 0;
  logic        s_ready;
  logic [7:0]  s_data = '0;
  logic        we1;
  logic [7:0]  in_addr;
  logic [33:0] ram1_data_in;
  logic [17:0] ram2_data_in;
  logic        busy, load_done, load_err;

  bdd_table_loader dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .we1(we1), .in_addr(in_addr), .ram1_data_in(ram1_data_in), .ram2_data_in(ram2_data_in),
    .busy(busy), .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  addr;
    logic [33:0] r1;
    logic [17:0] r2;
  } wr_t;

  wr_t         exp_q[$];
  int          total = 0;
  int          bad   = 0;
  logic [39:0] node_r1 [0:31];
  logic [23:0] node_r2 [0:31];

  // Write monitor: scoreboard pop on we1 rise, hold length and s_ready during write.
  logic we1_prev = 0;
  int   hold_cnt = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (we1 && !we1_prev) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_write addr=%0h ram1=%0h ram2=%0h (no write expected)",
                   in_addr, ram1_data_in, ram2_data_in);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          if ({in_addr, ram1_data_in, ram2_data_in} !== e) begin
            bad++;
            $display("FAIL write_data got addr=%0h ram1=%0h ram2=%0h exp addr=%0h ram1=%0h ram2=%0h",
                     in_addr, ram1_data_in, ram2_data_in, e.addr, e.r1, e.r2);
          end
        end
        hold_cnt = 1;
      end else if (we1) hold_cnt++;
      if (!we1 && we1_prev) begin
        total++;
        if (hold_cnt !== 4) begin
          bad++;
          $display("FAIL we1_hold got=%0d exp=4", hold_cnt);
        end
      end
      if (we1 && s_ready) begin
        total++; bad++;
        $display("FAIL ready_in_write got s_ready=1 exp=0");
      end
    end
    we1_prev = we1;
  end

  task automatic send_byte(input logic [7:0] b, input int gaps);
    logic rdy;
    int   t;
    s_valid = 0;
    repeat (gaps) begin @(posedge clk); #1; end
    s_valid = 1;
    s_data  = b;
    t = 0;
    do begin
      rdy = s_ready;
      @(posedge clk); #1;
      t++;
    end while (!rdy && t < 200);
    if (!rdy) begin
      total++; bad++;
      $display("FAIL byte_timeout byte=%0h not accepted within 200 cycles", b);
    end
    s_valid = 0;
  endtask

  function automatic logic [7:0] frame_csum(input int n);
    logic [7:0] x;
    x = 8'(n);
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 5; k++) x ^= node_r1[i][8*k +: 8];
      for (int k = 0; k < 3; k++) x ^= node_r2[i][8*k +: 8];
    end
    return x;
  endfunction

  task automatic send_frame(input int n, input logic [7:0] flip, input int maxgap, input logic exp_ok);
    send_byte(8'hA5, $urandom_range(0, maxgap));
    total++;
    if (load_done !== 1'b0 || load_err !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL header_clears got done=%b err=%b busy=%b exp 0 0 1", load_done, load_err, busy);
    end
    send_byte(8'(n), $urandom_range(0, maxgap));
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({8'(i), node_r1[i][33:0], node_r2[i][17:0]});
      for (int k = 4; k >= 0; k--) send_byte(node_r1[i][8*k +: 8], $urandom_range(0, maxgap));
      for (int k = 2; k >= 0; k--) send_byte(node_r2[i][8*k +: 8], $urandom_range(0, maxgap));
    end
    send_byte(frame_csum(n) ^ flip, $urandom_range(0, maxgap));
    total++;
    if (load_done !== exp_ok || load_err !== !exp_ok || busy !== 1'b0) begin
      bad++;
      $display("FAIL frame_status got done=%b err=%b busy=%b exp done=%b err=%b busy=0",
               load_done, load_err, busy, exp_ok, !exp_ok);
    end
  endtask

  task automatic set_plan_nodes();
    node_r1[0] = 40'h00_0000_0123; node_r2[0] = 24'h000105;
    node_r1[1] = 40'h03_FFFF_FFFF; node_r2[1] = 24'h000081;
  endtask

  task automatic check_all_zero(input string tag);
    total++;
    if ({we1, in_addr, ram1_data_in, ram2_data_in, busy, load_done, load_err} !== '0) begin
      bad++;
      $display("FAIL %s got we1=%b addr=%0h ram1=%0h ram2=%0h busy=%b done=%b err=%b exp all 0",
               tag, we1, in_addr, ram1_data_in, ram2_data_in, busy, load_done, load_err);
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_outputs");
    total++;
    if (s_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", s_ready); end
    rst_n = 1;
    #1;
    total++;
    if (s_ready !== 1'b1) begin bad++; $display("FAIL ready_after_release got=%b exp=1", s_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_good_frame();
    set_plan_nodes();
    send_frame(2, 8'h00, 0, 1'b1);
  endtask

  task automatic test_bad_csum();
    set_plan_nodes();
    send_frame(2, 8'h01, 0, 1'b0);
  endtask

  task automatic test_bad_count();
    logic [7:0] cnts [2];
    cnts[0] = 8'h00; cnts[1] = 8'h21;
    for (int j = 0; j < 2; j++) begin
      send_byte(8'hA5, 0);
      send_byte(cnts[j], 0);
      total++;
      if (load_err !== 1'b1 || load_done !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL bad_count_%0h got err=%b done=%b busy=%b exp 1 0 0", cnts[j], load_err, load_done, busy);
      end
      repeat (6) @(posedge clk);
      #1;
    end
  endtask

  task automatic test_garbage_prefix();
    logic [7:0] junk [3];
    junk[0] = 8'h00; junk[1] = 8'hFF; junk[2] = 8'h5A;
    for (int j = 0; j < 3; j++) begin
      send_byte(junk[j], 1);
      total++;
      if (busy !== 1'b0 || s_ready !== 1'b1) begin
        bad++;
        $display("FAIL junk_%0h got busy=%b ready=%b exp 0 1", junk[j], busy, s_ready);
      end
    end
    set_plan_nodes();
    send_frame(2, 8'h00, 0, 1'b1);
  endtask

  task automatic test_gaps_full_depth();
    for (int i = 0; i < 32; i++) begin
      node_r1[i] = {8'($urandom), 32'($urandom)};
      node_r2[i] = 24'($urandom);
    end
    send_frame(32, 8'h00, 3, 1'b1);
  endtask

  task automatic test_reset_mid_write();
    node_r1[0] = 40'hAB_CDEF_0123; node_r2[0] = 24'hFE_DCBA;
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    exp_q.push_back({8'h00, node_r1[0][33:0], node_r2[0][17:0]});
    for (int k = 4; k >= 0; k--) send_byte(node_r1[0][8*k +: 8], 0);
    for (int k = 2; k >= 0; k--) send_byte(node_r2[0][8*k +: 8], 0);
    @(posedge clk); #1;
    total++;
    if (we1 !== 1'b1) begin bad++; $display("FAIL write_cycle2 got we1=%b exp=1", we1); end
    rst_n = 0;
    #1;
    check_all_zero("reset_mid_write");
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    node_r1[0] = 40'h00_1234_5678; node_r2[0] = 24'h00_3ABC;
    node_r1[1] = 40'h01_0000_0001; node_r2[1] = 24'h02_0002;
    node_r1[2] = 40'h02_8000_0000; node_r2[2] = 24'h01_FFFF;
    send_frame(3, 8'h00, 1, 1'b1);
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_bad_count();
    test_garbage_prefix();
    test_gaps_full_depth();
    test_reset_mid_write();
    repeat (10) @(posedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL missing_writes got pending=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
